// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan of a byte (two nibbles) and a mode digit.
// Optional macro SCAN_BLANK_EN inserts a blank GAP slot after each digit.
module display_scan_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Enable,
    input  logic       Mode,
    input  logic [7:0] Data,
    input  logic       DataValid,
    output logic [1:0] Array,
    output logic [7:0] DispData,
    output logic       DispMode,
    output logic       FrameDone
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif
    state_t       state;
    logic [W-1:0] cnt;
    logic [1:0]   slot;
    logic [7:0]   pending;
    logic         tick;
    logic         last;
    logic [7:0]   next_byte;
    assign tick = state != IDLE && cnt == W'(TICK_DIV - 1);
`ifdef SCAN_BLANK_EN
    assign last = state == GAP && slot == 2'd2;
`else
    assign last = state == SCAN && slot == 2'd2;
`endif
    // a strobe coinciding with the boundary goes straight into the new frame
    assign next_byte = DataValid ? Data : pending;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            slot      <= 2'd0;
            Array     <= 2'd3;
            DispData  <= 8'h00;
            DispMode  <= 1'b0;
            pending   <= 8'h00;
            FrameDone <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            if (DataValid)
                pending <= Data;
            if (!Enable) begin
                state <= IDLE;
                cnt   <= '0;
                Array <= 2'd3;
            end else if (state == IDLE) begin
                state    <= SCAN;
                cnt      <= '0;
                slot     <= 2'd0;
                Array    <= 2'd0;
                DispData <= next_byte;
                DispMode <= Mode;
            end else if (!tick) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
`ifdef SCAN_BLANK_EN
                if (state == SCAN) begin
                    state <= GAP;
                    Array <= 2'd3;
                end else begin
                    state <= SCAN;
                    slot  <= last ? 2'd0 : slot + 2'd1;
                    Array <= last ? 2'd0 : slot + 2'd1;
                end
`else
                slot  <= last ? 2'd0 : slot + 2'd1;
                Array <= last ? 2'd0 : slot + 2'd1;
`endif
                if (last) begin
                    FrameDone <= 1'b1;
                    DispData  <= next_byte;
                    DispMode  <= Mode;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan order, frame-stable data and reset.
module tb_display_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Enable = 1'b0;
    logic       Mode = 1'b0;
    logic [7:0] Data = 8'h00;
    logic       DataValid = 1'b0;
    logic [1:0] Array;
    logic [7:0] DispData;
    logic       DispMode;
    logic       FrameDone;
    int         total = 0;
    int         passed = 0;

    display_scan_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .Enable(Enable), .Mode(Mode), .Data(Data),
        .DataValid(DataValid), .Array(Array), .DispData(DispData),
        .DispMode(DispMode), .FrameDone(FrameDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        chk("rst_array", 32'(Array), 3);
        chk("rst_data", 32'(DispData), 8'h00);
        chk("rst_mode", 32'(DispMode), 0);
        chk("rst_fd", 32'(FrameDone), 0);
        reset = 1'b0;
        Enable = 1'b1;
        Mode = 1'b1;
        step(1);
        chk("entry_mode", 32'(DispMode), 1);
        for (int i = 0; i <= 16; i++) begin
            chk($sformatf("seq_array%0d", i), 32'(Array), 32'((i / 4) % 3));
            chk($sformatf("seq_fd%0d", i), 32'(FrameDone), 32'(i == 12));
            step(1);
        end
        Data = 8'hA5;
        DataValid = 1'b1;
        step(1);
        DataValid = 1'b0;
        chk("hold_a5", 32'(DispData), 8'h00);
        step(2);
        Data = 8'h3C;
        DataValid = 1'b1;
        step(1);
        DataValid = 1'b0;
        chk("hold_3c", 32'(DispData), 8'h00);
        step(2);
        chk("tick_cycle_data", 32'(DispData), 8'h00);
        step(1);
        chk("frame_3c", 32'(DispData), 8'h3C);
        chk("frame_array", 32'(Array), 0);
        chk("frame_fd", 32'(FrameDone), 1);
        Mode = 1'b0;
        step(6);
        chk("mode_stable", 32'(DispMode), 1);
        step(5);
        chk("bnd_array", 32'(Array), 2);
        Data = 8'h7E;
        DataValid = 1'b1;
        step(1);
        DataValid = 1'b0;
        chk("bypass_7e", 32'(DispData), 8'h7E);
        chk("bypass_array", 32'(Array), 0);
        chk("bypass_mode", 32'(DispMode), 0);
        step(5);
        chk("slot1", 32'(Array), 1);
        Enable = 1'b0;
        step(1);
        chk("dis_array", 32'(Array), 3);
        chk("dis_fd", 32'(FrameDone), 0);
        step(2);
        chk("dis_hold", 32'(Array), 3);
        Enable = 1'b1;
        step(1);
        for (int k = 0; k <= 4; k++) begin
            chk($sformatf("reen%0d", k), 32'(Array), (k < 4) ? 0 : 1);
            step(1);
        end
        chk("reen_data", 32'(DispData), 8'h7E);
        Data = 8'h55;
        DataValid = 1'b1;
        step(1);
        DataValid = 1'b0;
        step(2);
        chk("pre_rst_slot2", 32'(Array), 2);
        reset = 1'b1;
        Data = 8'h99;
        DataValid = 1'b1;
        step(1);
        chk("mid_rst_array", 32'(Array), 3);
        chk("mid_rst_data", 32'(DispData), 8'h00);
        chk("mid_rst_fd", 32'(FrameDone), 0);
        reset = 1'b0;
        DataValid = 1'b0;
        step(1);
        chk("post_rst_array", 32'(Array), 0);
        chk("post_rst_data", 32'(DispData), 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
